exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage.sv | 177 +++++++++++++++++
 tb/tb_exe_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: barrel shifter, ALU with NZCV status register, branch target adder
// and a multi-cycle radix-2 shift-add multiplier that stalls the front of the pipeline.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        B,
  input  logic        S,
  input  logic        imm,
  input  logic [3:0]  EXE_CMD,
  input  logic [3:0]  Dest,
  input  logic [31:0] PC,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  output logic [31:0] ALU_Res,
  output logic [31:0] Val_Rm_out,
  output logic [3:0]  Dest_out,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic        Branch_taken,
  output logic [31:0] Branch_Address,
  output logic [3:0]  SR,
  output logic        stall
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

  mulState_t   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [3:0]  sr_q, sr_d;

  logic [31:0] val2;
  logic [63:0] rotTmp;
  logic [4:0]  shAmt;
  logic [3:0]  opCmd;
  logic        isMul;
  logic [31:0] aluOut;
  logic [31:0] addB;
  logic        addCin;
  logic [32:0] sum33;
  logic        isArith;
  logic        flagsValid;
  logic [3:0]  newFlags;

  // Memory accesses always compute their address with an add.
  assign opCmd = (MEM_R_EN | MEM_W_EN) ? CMD_ADD : EXE_CMD;
  assign isMul = (opCmd == CMD_MUL);
  assign stall = (state_q == BUSY) || ((state_q == IDLE) && isMul);

  always_comb begin
    val2   = '0;
    rotTmp = '0;
    shAmt  = Shift_operand[11:7];
    if (imm) begin
      rotTmp = {24'b0, Shift_operand[7:0], 24'b0, Shift_operand[7:0]} >> {Shift_operand[11:8], 1'b0};
      val2   = rotTmp[31:0];
    end else if (MEM_R_EN || MEM_W_EN) begin
      val2 = {20'b0, Shift_operand};
    end else begin
      case (Shift_operand[6:5])
        2'b00: val2 = Val_Rm << shAmt;
        2'b01: val2 = Val_Rm >> shAmt;
        2'b10: val2 = $unsigned($signed(Val_Rm) >>> shAmt);
        default: begin
          rotTmp = {Val_Rm, Val_Rm} >> shAmt;
          val2   = rotTmp[31:0];
        end
      endcase
    end
  end

  // Subtracts reuse the adder as Rn + ~Val2 + cin, so carry-out is NOT borrow.
  always_comb begin
    aluOut     = '0;
    addB       = val2;
    addCin     = 1'b0;
    isArith    = 1'b0;
    flagsValid = 1'b1;
    case (opCmd)
      CMD_MOV: aluOut = val2;
      CMD_MVN: aluOut = ~val2;
      CMD_ADD: isArith = 1'b1;
      CMD_ADC: begin isArith = 1'b1; addCin = sr_q[1]; end
      CMD_SUB: begin isArith = 1'b1; addB = ~val2; addCin = 1'b1; end
      CMD_SBC: begin isArith = 1'b1; addB = ~val2; addCin = sr_q[1]; end
      CMD_AND: aluOut = Val_Rn & val2;
      CMD_ORR: aluOut = Val_Rn | val2;
      CMD_EOR: aluOut = Val_Rn ^ val2;
      CMD_MUL: aluOut = (state_q == DONE) ? acc_q : 32'b0;
      default: flagsValid = 1'b0;
    endcase
    sum33 = {1'b0, Val_Rn} + {1'b0, addB} + {32'b0, addCin};
    if (isArith) aluOut = sum33[31:0];
    newFlags = {aluOut[31], (aluOut == 32'b0), sr_q[1], sr_q[0]};
    if (isArith) begin
      newFlags[1] = sum33[32];
      newFlags[0] = (Val_Rn[31] == addB[31]) && (sum33[31] != Val_Rn[31]);
    end
    sr_d = (S && flagsValid && !stall) ? newFlags : sr_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      IDLE: begin
        if (isMul) begin
          mcand_d  = Val_Rn;
          mplier_d = Val_Rm;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sr_q     <= sr_d;
    end
  end

  assign ALU_Res        = aluOut;
  assign SR             = sr_q;
  assign Val_Rm_out     = Val_Rm;
  assign Dest_out       = Dest;
  assign WB_EN_out      = WB_EN & ~stall;
  assign MEM_R_EN_out   = MEM_R_EN & ~stall;
  assign MEM_W_EN_out   = MEM_W_EN & ~stall;
  assign Branch_taken   = B & ~stall;
  assign Branch_Address = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a table of single-cycle ALU/shifter/branch vectors
// followed by hand-written multiply, bubble and reset-abort sequences.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm;
  logic [3:0]  EXE_CMD, Dest;
  logic [31:0] PC, Val_Rn, Val_Rm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [31:0] ALU_Res, Val_Rm_out, Branch_Address;
  logic [3:0]  Dest_out, SR;
  logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, Branch_taken, stall;

  int checks = 0;
  int errors = 0;

  exe_stage dut (
    .clk(clk), .rst(rst),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S), .imm(imm),
    .EXE_CMD(EXE_CMD), .Dest(Dest), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
    .ALU_Res(ALU_Res), .Val_Rm_out(Val_Rm_out), .Dest_out(Dest_out),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .Branch_taken(Branch_taken), .Branch_Address(Branch_Address), .SR(SR), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, memR, memW, wb, b;
    logic [31:0] rn, rm;
    logic [11:0] shOp;
    logic [31:0] pc;
    logic [23:0] simm;
    logic [31:0] expRes;
    logic [31:0] expBr;
    logic [3:0]  expSr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic [3:0] cmd, logic s, logic im, logic memR, logic memW,
                                 logic wb, logic b, logic [31:0] rn, logic [31:0] rm,
                                 logic [11:0] shOp, logic [31:0] pc, logic [23:0] simm,
                                 logic [31:0] expRes, logic [31:0] expBr, logic [3:0] expSr);
    vec_t v;
    v.cmd = cmd; v.s = s; v.imm = im; v.memR = memR; v.memW = memW; v.wb = wb; v.b = b;
    v.rn = rn; v.rm = rm; v.shOp = shOp; v.pc = pc; v.simm = simm;
    v.expRes = expRes; v.expBr = expBr; v.expSr = expSr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic [3:0] dest);
    EXE_CMD = v.cmd; S = v.s; imm = v.imm; MEM_R_EN = v.memR; MEM_W_EN = v.memW;
    WB_EN = v.wb; B = v.b; Val_Rn = v.rn; Val_Rm = v.rm; Shift_operand = v.shOp;
    PC = v.pc; Signed_imm_24 = v.simm; Dest = dest;
  endtask

  // Drives a multiply, counts stalled cycles (checking the bubble), then checks the DONE cycle.
  task automatic runMul(input int tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expProd, input logic [3:0] srBefore,
                        input logic [3:0] srAfter);
    int stallCycles;
    applyStimulus(mkVec(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, b, 12'h0,
                        32'h0, 24'h0, 32'h0, 32'h0, 4'h0), 4'd9);
    #2;
    stallCycles = 0;
    while (stall === 1'b1 && stallCycles < 40) begin
      stallCycles++;
      checkOutput("mulBubbleWb", tag, {31'b0, WB_EN_out}, 32'h0);
      checkOutput("mulBubbleBt", tag, {31'b0, Branch_taken}, 32'h0);
      @(posedge clk); #1;
    end
    checkOutput("mulStallCycles", tag, stallCycles, 33);
    checkOutput("mulSrHeld", tag, {28'b0, SR}, {28'b0, srBefore});
    checkOutput("mulDoneStall", tag, {31'b0, stall}, 32'h0);
    checkOutput("mulProduct", tag, ALU_Res, expProd);
    checkOutput("mulDoneWb", tag, {31'b0, WB_EN_out}, 32'h1);
    @(posedge clk); #1;
    checkOutput("mulSrAfter", tag, {28'b0, SR}, {28'b0, srAfter});
    applyStimulus(mkVec(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0,
                        32'h0, 24'h0, 32'h0, 32'h0, 4'h0), 4'd0);
    #2;
    checkOutput("mulAfterStall", tag, {31'b0, stall}, 32'h0);
  endtask

  initial begin
    // cmd s imm memR memW wb b  rn rm shOp pc simm  expRes expBr expSr
    vecs.push_back(mkVec(4'b0010,1,1,0,0,1,0, 32'h7FFFFFFF,0,12'h001,0,0, 32'h80000000,0,4'h9));
    vecs.push_back(mkVec(4'b0100,1,1,0,0,1,0, 32'h5,0,12'h005,0,0, 32'h0,0,4'h6));
    vecs.push_back(mkVec(4'b0011,0,1,0,0,1,0, 32'h1,0,12'h001,0,0, 32'h3,0,4'h6));
    vecs.push_back(mkVec(4'b0001,1,0,0,0,1,0, 0,32'h80000001,12'h0E0,0,0, 32'hC0000000,0,4'hA));
    vecs.push_back(mkVec(4'b0001,0,0,0,0,1,0, 0,32'h80000001,12'h240,0,0, 32'hF8000000,0,4'hA));
    vecs.push_back(mkVec(4'b1001,1,1,0,0,1,0, 0,0,12'h0FF,0,0, 32'hFFFFFF00,0,4'hA));
    vecs.push_back(mkVec(4'b0101,1,1,0,0,1,0, 32'hA,0,12'h003,0,0, 32'h7,0,4'h2));
    vecs.push_back(mkVec(4'b0100,1,1,0,0,1,0, 32'h3,0,12'h005,0,0, 32'hFFFFFFFE,0,4'h8));
    vecs.push_back(mkVec(4'b0101,0,1,0,0,1,0, 32'hA,0,12'h003,0,0, 32'h6,0,4'h8));
    vecs.push_back(mkVec(4'b0011,0,1,0,0,1,0, 32'hA,0,12'h003,0,0, 32'hD,0,4'h8));
    vecs.push_back(mkVec(4'b0110,1,1,0,0,1,0, 32'hF0F0F0F0,0,12'h40F,0,0, 32'h0,0,4'h4));
    vecs.push_back(mkVec(4'b0111,0,1,0,0,1,0, 32'h12340000,0,12'h0AB,0,0, 32'h123400AB,0,4'h4));
    vecs.push_back(mkVec(4'b1000,1,1,0,0,1,0, 32'hFFFFFFFF,0,12'h0FF,0,0, 32'hFFFFFF00,0,4'h8));
    vecs.push_back(mkVec(4'b0010,1,1,0,0,1,0, 32'hFFFFFFFF,0,12'h001,0,0, 32'h0,0,4'h6));
    vecs.push_back(mkVec(4'b1111,1,1,0,0,1,0, 32'h5,0,12'h001,0,0, 32'h0,0,4'h6));
    vecs.push_back(mkVec(4'b0010,0,0,1,0,1,0, 32'h1000,0,12'hFFF,0,0, 32'h1FFF,0,4'h6));
    vecs.push_back(mkVec(4'b0010,0,0,0,1,0,0, 32'h20,32'hDEADBEEF,12'h004,0,0, 32'h24,0,4'h6));
    vecs.push_back(mkVec(4'b0001,0,0,0,0,1,0, 0,32'h3,12'h200,0,0, 32'h30,0,4'h6));
    vecs.push_back(mkVec(4'b0001,0,0,0,0,1,0, 0,32'h80000000,12'hFA0,0,0, 32'h1,0,4'h6));
    vecs.push_back(mkVec(4'b0000,0,0,0,0,0,1, 0,0,12'h000,32'h100,24'hFFFFFE, 32'h0,32'hF8,4'h6));
    vecs.push_back(mkVec(4'b0000,0,0,0,0,0,1, 0,0,12'h000,32'h0,24'h000010, 32'h0,32'h40,4'h6));
    vecs.push_back(mkVec(4'b0100,1,1,0,0,1,0, 32'h80000000,0,12'h001,0,0, 32'h7FFFFFFF,0,4'h3));

    rst = 1'b1;
    applyStimulus(mkVec(4'h0,0,0,0,0,0,0, 0,0,12'h0,0,0, 0,0,4'h0), 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("resetSr", 0, {28'b0, SR}, 32'h0);
    checkOutput("resetStall", 0, {31'b0, stall}, 32'h0);
    checkOutput("resetRes", 0, ALU_Res, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i[3:0]);
      #2;
      checkOutput("aluRes", i, ALU_Res, vecs[i].expRes);
      checkOutput("brAddr", i, Branch_Address, vecs[i].expBr);
      checkOutput("brTaken", i, {31'b0, Branch_taken}, {31'b0, vecs[i].b});
      checkOutput("wbOut", i, {31'b0, WB_EN_out}, {31'b0, vecs[i].wb});
      checkOutput("memOut", i, {30'b0, MEM_R_EN_out, MEM_W_EN_out}, {30'b0, vecs[i].memR, vecs[i].memW});
      checkOutput("passRm", i, Val_Rm_out, vecs[i].rm);
      checkOutput("passDest", i, {28'b0, Dest_out}, {28'b0, i[3:0]});
      checkOutput("stallLow", i, {31'b0, stall}, 32'h0);
      @(posedge clk); #1;
      checkOutput("srAfter", i, {28'b0, SR}, {28'b0, vecs[i].expSr});
    end

    // 0x10000 squared wraps to zero: Z set, C/V kept from the last SUBS (0011).
    runMul(1, 32'h00010000, 32'h00010000, 32'h0, 4'h3, 4'h7);

    // Abort a multiply partway through BUSY; the ID/EXE register is flushed with the reset.
    applyStimulus(mkVec(4'b1010,1,0,0,0,1,0, 32'h5,32'h5,12'h0,0,0, 0,0,4'h0), 4'd1);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("abortBusyStall", 2, {31'b0, stall}, 32'h1);
    rst = 1'b1;
    applyStimulus(mkVec(4'h0,0,0,0,0,0,0, 0,0,12'h0,0,0, 0,0,4'h0), 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("abortStall", 2, {31'b0, stall}, 32'h0);
    checkOutput("abortSr", 2, {28'b0, SR}, 32'h0);
    checkOutput("abortRes", 2, ALU_Res, 32'h0);
    @(posedge clk); #1;
    checkOutput("abortNoDone", 2, {31'b0, stall}, 32'h0);

    runMul(3, 32'h3, 32'h7, 32'd21, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
